// File: rtl/buzzer_pkg.sv
// Shared types and display helpers for the buzzer lockout arbiter.
// The optional false-start feature is enabled with BUZZER_FALSE_START_EN.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DASH  = 7'b100_0000;

    // Decimal digit to 7-segment pattern; anything outside 0..9 is blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg_v;
        case (digit)
            4'd0:    seg_v = 7'b011_1111;
            4'd1:    seg_v = 7'b000_0110;
            4'd2:    seg_v = 7'b101_1011;
            4'd3:    seg_v = 7'b100_1111;
            4'd4:    seg_v = 7'b110_0110;
            4'd5:    seg_v = 7'b110_1101;
            4'd6:    seg_v = 7'b111_1101;
            4'd7:    seg_v = 7'b000_0111;
            4'd8:    seg_v = 7'b111_1111;
            4'd9:    seg_v = 7'b110_1111;
            default: seg_v = SEG_BLANK;
        endcase
        return seg_v;
    endfunction

endpackage

// File: rtl/buzzer_sync_edge.sv
// Two-flop synchroniser for raw asynchronous buttons followed by a third
// flop so that only a low-to-high transition produces a one-cycle press.
module buzzer_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_r;
    logic [W-1:0] s2_r;
    logic [W-1:0] s3_r;

    // Metastability chain plus the previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= {W{1'b0}};
            s2_r <= {W{1'b0}};
            s3_r <= {W{1'b0}};
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/buzzer_lockout_arbiter.sv
// Quiz buzzer judge: the host arms a round, the first player press edge wins
// and everyone else is locked out. Reports winner, 7-seg digit, reaction time
// and a timeout when nobody presses in time.
// Optional false-start masking: define BUZZER_FALSE_START_EN.
module buzzer_lockout_arbiter
    import buzzer_pkg::*;
#(
    parameter int NUM_PLAYERS    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = 16,
    parameter int TIE_MODE       = 0,
    parameter int IDW            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   clear,
    input  logic [NUM_PLAYERS-1:0] player,
    output logic                   flag,
    output logic                   winner_valid,
    output logic [IDW-1:0]         winner_id,
    output logic [6:0]             display,
    output logic [TW-1:0]          reaction,
    output logic                   timeout
`ifdef BUZZER_FALSE_START_EN
   ,output logic [NUM_PLAYERS-1:0] foul_mask
`endif
);

    localparam logic [TW-1:0]  CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]  CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]  CNT_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0]  CNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_ZERO  = {IDW{1'b0}};
    localparam logic [IDW-1:0] ID_ONE   = {{(IDW-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_PLAYERS - 1);
    localparam logic [IDW:0]   NUM_EXT  = (IDW+1)'(NUM_PLAYERS);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [TW-1:0]            counter_r;
    logic [TW-1:0]            counter_nxt_s;
    logic [TW-1:0]            reaction_nxt_s;
    logic [IDW-1:0]           winner_nxt_s;
    logic [IDW-1:0]           ptr_r;
    logic [IDW-1:0]           ptr_nxt_s;
    logic [IDW-1:0]           pick_s;
    logic [NUM_PLAYERS-1:0]   press_s;
    logic [NUM_PLAYERS-1:0]   eligible_s;
    logic [3:0]               digit_s;
`ifdef BUZZER_FALSE_START_EN
    logic [NUM_PLAYERS-1:0]   foul_nxt_s;
`endif

    // Winner among requesters: lowest index, or first index at/after the
    // rotating pointer when TIE_MODE is 1. Rotate, find lowest, rotate back.
    function automatic logic [IDW-1:0] pick_winner(
        input logic [NUM_PLAYERS-1:0] req,
        input logic [IDW-1:0]         start
    );
        logic [NUM_PLAYERS-1:0] rot_v;
        logic [IDW-1:0]         base_v;
        logic [IDW-1:0]         off_v;
        logic [IDW:0]           sum_v;
        logic                   found_v;
        base_v  = (TIE_MODE == 1) ? start : ID_ZERO;
        rot_v   = NUM_PLAYERS'({req, req} >> base_v);
        off_v   = ID_ZERO;
        found_v = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!found_v && rot_v[IDW'(i)]) begin
                off_v   = IDW'(i);
                found_v = 1'b1;
            end
        end
        sum_v = {1'b0, base_v} + {1'b0, off_v};
        if (sum_v >= NUM_EXT) begin
            sum_v = sum_v - NUM_EXT;
        end
        return sum_v[IDW-1:0];
    endfunction

    buzzer_sync_edge #(
        .W (NUM_PLAYERS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (player),
        .rise  (press_s)
    );

    // Presses that may win this round (fouled players sit the round out).
    always_comb begin
`ifdef BUZZER_FALSE_START_EN
        eligible_s = press_s & ~foul_mask;
`else
        eligible_s = press_s;
`endif
        pick_s = pick_winner(eligible_s, ptr_r);
    end

    // Round FSM next state; clear dominates, a press beats the timeout.
    always_comb begin
        state_nxt_s    = state_r;
        counter_nxt_s  = counter_r;
        winner_nxt_s   = winner_id;
        reaction_nxt_s = reaction;
        ptr_nxt_s      = ptr_r;
`ifdef BUZZER_FALSE_START_EN
        foul_nxt_s     = foul_mask;
`endif
        case (state_r)
            ARMED: begin
                if (clear) begin
                    state_nxt_s = IDLE;
                end else if (|eligible_s) begin
                    state_nxt_s    = LOCKED;
                    winner_nxt_s   = pick_s;
                    reaction_nxt_s = (counter_r == CNT_MAX) ? CNT_MAX : counter_r + CNT_ONE;
                    ptr_nxt_s      = (pick_s == ID_LAST) ? ID_ZERO : pick_s + ID_ONE;
`ifdef BUZZER_FALSE_START_EN
                    foul_nxt_s     = {NUM_PLAYERS{1'b0}};
`endif
                end else if (counter_r == CNT_LAST) begin
                    state_nxt_s = TIMEOUT;
`ifdef BUZZER_FALSE_START_EN
                    foul_nxt_s  = {NUM_PLAYERS{1'b0}};
`endif
                end else begin
                    counter_nxt_s = (counter_r == CNT_MAX) ? CNT_MAX : counter_r + CNT_ONE;
                end
            end
            IDLE, LOCKED, TIMEOUT: begin
`ifdef BUZZER_FALSE_START_EN
                foul_nxt_s = foul_mask | press_s;
`endif
                if (clear) begin
                    state_nxt_s = IDLE;
                end else if (arm) begin
                    state_nxt_s   = ARMED;
                    counter_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Digit shown for a winner is its 1-based number.
    always_comb begin
        digit_s = 4'(winner_nxt_s) + 4'd1;
    end

    // State, counters and all outputs registered from the next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            counter_r    <= CNT_ZERO;
            ptr_r        <= ID_ZERO;
            flag         <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= ID_ZERO;
            display      <= SEG_BLANK;
            reaction     <= CNT_ZERO;
            timeout      <= 1'b0;
`ifdef BUZZER_FALSE_START_EN
            foul_mask    <= {NUM_PLAYERS{1'b0}};
`endif
        end else begin
            state_r      <= state_nxt_s;
            counter_r    <= counter_nxt_s;
            ptr_r        <= ptr_nxt_s;
            flag         <= (state_nxt_s == LOCKED);
            winner_valid <= (state_nxt_s == LOCKED);
            winner_id    <= (state_nxt_s == LOCKED) ? winner_nxt_s : ID_ZERO;
            reaction     <= (state_nxt_s == LOCKED) ? reaction_nxt_s : CNT_ZERO;
            timeout      <= (state_nxt_s == TIMEOUT);
`ifdef BUZZER_FALSE_START_EN
            foul_mask    <= foul_nxt_s;
`endif
            case (state_nxt_s)
                LOCKED:  display <= seg_digit(digit_s);
                TIMEOUT: display <= SEG_DASH;
                default: display <= SEG_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_lockout_arbiter.sv
// Randomised + directed bench for buzzer_lockout_arbiter. Two instances share
// the stimulus: one lowest-index tie-break, one rotating. A behavioural model
// predicts each cycle's outputs into per-instance queues; a negedge monitor
// pops and compares. Define BUZZER_FALSE_START_EN to cover foul masking.
module tb_buzzer_lockout_arbiter;

    localparam int N  = 4;
    localparam int T  = 8;
    localparam int TW = 16;

    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_LOCK = 2;
    localparam int S_TO   = 3;

    typedef struct packed {
        logic          flag;
        logic          wv;
        logic [1:0]    wid;
        logic [6:0]    disp;
        logic [TW-1:0] react;
        logic          to;
        logic [N-1:0]  foul;
    } out_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arm;
    logic         clear;
    logic [N-1:0] player;

    logic          flag0, wv0, to0, flag1, wv1, to1;
    logic [1:0]    wid0, wid1;
    logic [6:0]    disp0, disp1;
    logic [TW-1:0] react0, react1;
    logic [N-1:0]  foul0, foul1;
    out_t          act0, act1;

    always #5 clk = ~clk;

    buzzer_lockout_arbiter #(.NUM_PLAYERS(N), .TIMEOUT_CYCLES(T), .TW(TW), .TIE_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .player(player),
        .flag(flag0), .winner_valid(wv0), .winner_id(wid0), .display(disp0),
        .reaction(react0), .timeout(to0)
`ifdef BUZZER_FALSE_START_EN
       ,.foul_mask(foul0)
`endif
    );

    buzzer_lockout_arbiter #(.NUM_PLAYERS(N), .TIMEOUT_CYCLES(T), .TW(TW), .TIE_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .player(player),
        .flag(flag1), .winner_valid(wv1), .winner_id(wid1), .display(disp1),
        .reaction(react1), .timeout(to1)
`ifdef BUZZER_FALSE_START_EN
       ,.foul_mask(foul1)
`endif
    );

`ifndef BUZZER_FALSE_START_EN
    assign foul0 = {N{1'b0}};
    assign foul1 = {N{1'b0}};
`endif

    assign act0 = {flag0, wv0, wid0, disp0, react0, to0, foul0};
    assign act1 = {flag1, wv1, wid1, disp1, react1, to1, foul1};

    // ---------------- reference model ----------------
    int           m_st[2];
    int           m_cnt[2];
    int           m_win[2];
    int           m_react[2];
    int           m_ptr[2];
    logic [N-1:0] m_foul[2];
    logic [N-1:0] raw_hist[3];   // [0]=sampled 1 edge ago, [1]=2 ago, [2]=3 ago
    logic [6:0]   seg_tab[10];

    out_t q0[$];
    out_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m]    = S_IDLE;
            m_cnt[m]   = 0;
            m_win[m]   = 0;
            m_react[m] = 0;
            m_ptr[m]   = 0;
            m_foul[m]  = '0;
        end
        for (int h = 0; h < 3; h++) raw_hist[h] = '0;
    endtask

    // Spec rule: instance 0 lowest index, instance 1 first at/after pointer.
    function automatic int pick(int m, logic [N-1:0] req);
        int start;
        start = (m == 1) ? m_ptr[m] : 0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (start + i) % N;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    // Advance the model over one rising clock edge using current inputs.
    task automatic model_edge();
        logic [N-1:0] press;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // A press is seen when the button was high two edges ago, low three ago.
        press = raw_hist[1] & ~raw_hist[2];
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0] elig;
            elig = press & ~m_foul[m];
            if (m_st[m] == S_ARM) begin
                if (clear) begin
                    m_st[m] = S_IDLE;
                end else if (elig != '0) begin
                    m_win[m]   = pick(m, elig);
                    m_st[m]    = S_LOCK;
                    m_react[m] = (m_cnt[m] + 1 > 2**TW - 1) ? 2**TW - 1 : m_cnt[m] + 1;
                    m_ptr[m]   = (m_win[m] + 1) % N;
                    m_foul[m]  = '0;
                end else if (m_cnt[m] == T - 1) begin
                    m_st[m]   = S_TO;
                    m_foul[m] = '0;
                end else begin
                    m_cnt[m] = m_cnt[m] + 1;
                end
            end else begin
`ifdef BUZZER_FALSE_START_EN
                m_foul[m] = m_foul[m] | press;
`endif
                if (clear) begin
                    m_st[m] = S_IDLE;
                end else if (arm) begin
                    m_st[m]  = S_ARM;
                    m_cnt[m] = 0;
                end
            end
        end
        raw_hist[2] = raw_hist[1];
        raw_hist[1] = raw_hist[0];
        raw_hist[0] = player;
    endtask

    function automatic out_t model_out(int m);
        out_t o;
        o = '0;
        if (m_st[m] == S_LOCK) begin
            o.flag  = 1'b1;
            o.wv    = 1'b1;
            o.wid   = 2'(m_win[m]);
            o.disp  = seg_tab[m_win[m] + 1];
            o.react = TW'(m_react[m]);
        end else if (m_st[m] == S_TO) begin
            o.to   = 1'b1;
            o.disp = 7'b1000000;
        end
        o.foul = m_foul[m];
        return o;
    endfunction

    // ---------------- stimulus ----------------
    // Wait for an edge, let the model consume it, then drive the next inputs.
    task automatic step(input logic a, input logic c, input logic [N-1:0] p, input logic r);
        @(posedge clk);
        model_edge();
        #1;
        arm    = a;
        clear  = c;
        player = p;
        rst_n  = r;
        if (!r) model_reset();
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    task automatic hold(input int n, input logic [N-1:0] p);
        repeat (n) step(1'b0, 1'b0, p, 1'b1);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int d, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, a, e);
        end
    endtask

    task automatic compare(input int d, input out_t a, input out_t e);
        chk("flag", d, 32'(a.flag), 32'(e.flag));
        chk("winner_valid", d, 32'(a.wv), 32'(e.wv));
        chk("winner_id", d, 32'(a.wid), 32'(e.wid));
        chk("display", d, 32'(a.disp), 32'(e.disp));
        chk("reaction", d, 32'(a.react), 32'(e.react));
        chk("timeout", d, 32'(a.to), 32'(e.to));
`ifdef BUZZER_FALSE_START_EN
        chk("foul_mask", d, 32'(a.foul), 32'(e.foul));
`endif
    endtask

    // Each cycle's prediction is pushed just after the edge; compare mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, act0, q0.pop_front());
        if (q1.size() > 0) compare(1, act1, q1.pop_front());
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [N-1:0] pl;
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; player = '0;
        model_reset();

        repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);
        hold(2, 4'b0000);

        // Player 2 rises 5 cycles after arm; later player 0 must not steal it.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(4, 4'b0000);
        hold(4, 4'b0100);
        hold(2, 4'b0000);
        hold(4, 4'b0001);
        hold(2, 4'b0000);

        // Player 1 wins alone, then a 1+3 tie after re-arming from LOCKED.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(2, 4'b0000);
        hold(3, 4'b0010);
        hold(3, 4'b0000);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(2, 4'b0000);
        hold(4, 4'b1010);
        hold(2, 4'b0000);

        // Press edge lands on the timeout cycle and must win.
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(5, 4'b0000);
        hold(4, 4'b0001);
        hold(2, 4'b0000);

        // Plain timeout; presses while timed out change nothing.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(10, 4'b0000);
        hold(4, 4'b0100);
        hold(2, 4'b0000);

        // Button held through arm is ignored until released and re-pressed.
        hold(3, 4'b0001);
        step(1'b1, 1'b0, 4'b0001, 1'b1);
        hold(3, 4'b0001);
        hold(2, 4'b0000);
        hold(4, 4'b0001);
        hold(1, 4'b0000);

        // Asynchronous reset while LOCKED.
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(3, 4'b1000);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        hold(2, 4'b0000);

        // clear and arm together in LOCKED return to IDLE.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(3, 4'b0100);
        step(1'b1, 1'b1, 4'b0000, 1'b1);
        hold(4, 4'b0000);

`ifdef BUZZER_FALSE_START_EN
        // False start by player 1 in IDLE: masked next round, player 2 wins.
        hold(3, 4'b0010);
        hold(2, 4'b0000);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        hold(2, 4'b0000);
        hold(3, 4'b0010);
        hold(1, 4'b0000);
        hold(3, 4'b0100);
        hold(2, 4'b0000);
        step(1'b0, 1'b1, 4'b0000, 1'b1);
`endif

        // Random phase.
        pl = '0;
        for (int i = 0; i < 800; i++) begin
            logic a, c, r;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) pl[b] = ~pl[b];
            end
            a = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) != 0);
            step(a, c, pl, r);
        end

        hold(3, 4'b0000);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
